fir_block_sequencer: RTL and testbench
======================================

# fir_block_sequencer

Streaming front-end and scheduler for the block FIR datapath (`FirFilter`). It does four things:
- Accepts 16-bit input samples one at a time over a valid/ready handshake.
- Packs `SAMPLES_NUM` samples into one block and issues a single start pulse when the filter is idle.
- Waits for the filter's done pulse and captures the 32-bit results.
- Replays the results one per handshake in sample order.

Collection of the next block overlaps with filtering and draining of the current one.

## Interface
- `SAMPLES_NUM`, 4, samples per block (1..8); must match the filter instance.
- `TIMEOUT_CYCLES`, 256, watchdog limit in WAIT (used only with `FIR_TIMEOUT_EN`).
- `clkIn`  in  1  single clock, rising edge.
- `nResetIn`  in  1  asynchronous, active-low reset.
- `sampleValidIn`  in  1  input sample present.
- `sampleIn`  in  16  signed input sample.
- `sampleReadyOut`  out  1  sequencer can accept a sample this cycle.
- `resultValidOut`  out  1  `resultOut` valid.
- `resultOut`  out  32  filtered sample.
- `resultReadyIn`  in  1  downstream accepts `resultOut`.
- `firStartOut`  out  1  one-cycle start pulse to the filter `startIn`.
- `firDataOut`  out  16*SAMPLES_NUM  block to the filter `dataIn`.
- `firBusyIn`  in  1  filter `busyOut`.
- `firDoneIn`  in  1  filter `doneOut` (one-cycle pulse).
- `firDataIn`  in  32*SAMPLES_NUM  filter `dataOut`.
- `errorOut`  out  1  sticky watchdog error.

## Operation
- **Collect side (independent of the FSM)**
  - Collect register plus counter `cnt` (0..SAMPLES_NUM).
  - `sampleReadyOut = (cnt != SAMPLES_NUM)`.
  - Accept when valid & ready: the k-th sample of a block (k=0 first) goes to bits [16k+15:16k]; `cnt++`.
- **FSM states: IDLE, START, WAIT, DRAIN**
  - IDLE: when `cnt == SAMPLES_NUM`, `firBusyIn == 0` and `firDoneIn == 0`:
    - copy the collect register into the `firDataOut` register;
    - clear `cnt`;
    - go to START.
  - START: `firStartOut = 1` for exactly this cycle; go to WAIT.
  - WAIT: on `firDoneIn`:
    - capture `firDataIn` into the result register;
    - set `idx = 0`;
    - go to DRAIN.
  - DRAIN: `resultValidOut = 1`.
    - Result `idx` is `firDataIn` slot [32*(SAMPLES_NUM-idx)-1 : 32*(SAMPLES_NUM-1-idx)]. The most significant slot is the oldest output.
    - On `resultReadyIn`, increment `idx`. On acceptance of the last slot, go to IDLE.
- `firDataOut` is held constant from START until the next IDLE→START transition.
- `resultOut` is held stable while valid and not ready.
- `firDoneIn` outside WAIT is ignored.
- `sampleIn` is passed through unmodified; no arithmetic beyond the counters.

## Timing
- **Reset values:** `sampleReadyOut = 1`, `resultValidOut = 0`, `resultOut = 0`, `firStartOut = 0`, `firDataOut = 0`, `errorOut = 0`. State = IDLE, `cnt = 0`, `idx = 0`.
- **Registered outputs:** all outputs are registered except `sampleReadyOut`, which is a combinational decode of `cnt`.
- **Launch latency:** last sample of a block accepted at edge t; IDLE→START at edge t+1; `firStartOut` is high for cycle t+1..t+2.
- **Result latency:** `firDoneIn` high in cycle c; `resultValidOut` high from edge c+1.
- **Throughput:** one sample per cycle while not full; one result per cycle under constant ready.
- **Full buffer:** `sampleReadyOut = 0` until the launch edge clears `cnt`. Back-to-back blocks therefore stall input only while a block is waiting for launch.
- **Simultaneous events:** an accept cannot coincide with the launch edge because ready is 0 then.
- **Filter busy or done:** if `firBusyIn` or `firDoneIn` is high in IDLE, the launch is deferred, with no pulse.
- **Mid-operation reset:** asynchronous return to the reset values. Any in-flight block and collected samples are discarded; no result is emitted.

## Configuration
- `FIR_TIMEOUT_EN` defined:
  - a WAIT cycle counter runs;
  - if `TIMEOUT_CYCLES` cycles elapse in WAIT without `firDoneIn`, set `errorOut = 1` (sticky until reset), discard the block and go to IDLE. No results are emitted for that block.
- `FIR_TIMEOUT_EN` not defined:
  - no counter;
  - `errorOut` tied to 0;
  - WAIT lasts indefinitely.

## Test plan
All scenarios use `SAMPLES_NUM = 4`.
- **Pack:** samples 1,2,3,4 on consecutive cycles → one `firStartOut` pulse 1 cycle after the 4th accept; `firDataOut = 0x0004_0003_0002_0001`.
- **Unpack:** `firDoneIn` with `firDataIn = {0xA, 0xB, 0xC, 0xD}` (MSB→LSB) and `resultReadyIn = 1` → `resultOut` = 0xA, 0xB, 0xC, 0xD on 4 consecutive cycles, then `resultValidOut = 0`.
- **Backpressure:** `resultReadyIn = 0` for 5 cycles in DRAIN → `resultOut` stays 0xA, valid stays 1; no slot skipped.
- **Overlap and stall:** during DRAIN send samples 5..9 continuously → 5..8 accepted; `sampleReadyOut = 0` for 9 until the next launch; the next `firDataOut = 0x0008_0007_0006_0005`.
- **Busy deferral:** `firBusyIn = 1` for 10 cycles with a full buffer → no start pulse until 1 cycle after `firBusyIn` falls.
- **Watchdog and reset:**
  - with `FIR_TIMEOUT_EN` and `TIMEOUT_CYCLES = 16`, no done → `errorOut = 1` after 16 WAIT cycles, FSM returns to IDLE;
  - assert `nResetIn` mid-DRAIN → all outputs return to reset values immediately; `errorOut = 0`.

Source files
------------

// File: rtl/fir_block_sequencer.sv
// fir_block_sequencer: packs input samples into blocks for the block FIR and replays its results in order.
// Defining FIR_TIMEOUT_EN adds a WAIT watchdog that sets a sticky errorOut and abandons the block.
module fir_block_sequencer #(
  parameter int SAMPLES_NUM    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clkIn,
  input  logic                      nResetIn,
  input  logic                      sampleValidIn,
  input  logic [15:0]               sampleIn,
  output logic                      sampleReadyOut,
  output logic                      resultValidOut,
  output logic [31:0]               resultOut,
  input  logic                      resultReadyIn,
  output logic                      firStartOut,
  output logic [16*SAMPLES_NUM-1:0] firDataOut,
  input  logic                      firBusyIn,
  input  logic                      firDoneIn,
  input  logic [32*SAMPLES_NUM-1:0] firDataIn,
  output logic                      errorOut
);
  typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_t;
  localparam int DW = 16*SAMPLES_NUM;
  localparam int RW = 32*SAMPLES_NUM;
  localparam logic [3:0] FULL = 4'(SAMPLES_NUM);
  localparam logic [2:0] LAST = 3'(SAMPLES_NUM-1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [DW-1:0] col_q, col_d, fdat_q, fdat_d;
  logic [RW-1:0] res_q, res_d;
  logic start_q, start_d, valid_q, valid_d, err_q, err_d;
  logic accept, launch, timeout;
  assign sampleReadyOut = cnt_q != FULL;
  assign accept = sampleValidIn && sampleReadyOut;
  assign launch = state_q == IDLE && cnt_q == FULL && !firBusyIn && !firDoneIn;
  assign cnt_d = launch ? 4'd0 : accept ? cnt_q + 4'd1 : cnt_q;
  assign fdat_d = launch ? col_q : fdat_q;
  assign start_d = launch;
  assign err_d = err_q | timeout;
  assign firStartOut = start_q;
  assign firDataOut = fdat_q;
  assign resultValidOut = valid_q;
  assign resultOut = res_q[RW-1 -: 32];
  assign errorOut = err_q;
`ifdef FIR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] wd_q, wd_d;
  assign wd_d = state_q == WAIT ? wd_q + 1'b1 : '0;
  assign timeout = state_q == WAIT && !firDoneIn && wd_q == TW'(TIMEOUT_CYCLES-1);
  always_ff @(posedge clkIn or negedge nResetIn)
    if (!nResetIn) wd_q <= '0;
    else wd_q <= wd_d;
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  always_comb begin
    col_d = col_q;
    if (accept) col_d[16*cnt_q +: 16] = sampleIn;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    res_d = res_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: state_d = launch ? START : IDLE;
      START: state_d = WAIT;
      WAIT:
        if (firDoneIn) begin
          res_d = firDataIn;
          idx_d = '0;
          valid_d = 1'b1;
          state_d = DRAIN;
        end else if (timeout) state_d = IDLE;
      DRAIN:
        if (resultReadyIn) begin
          res_d = res_q << 32;
          idx_d = idx_q + 3'd1;
          valid_d = idx_q != LAST;
          state_d = idx_q == LAST ? IDLE : DRAIN;
        end
    endcase
  end
  always_ff @(posedge clkIn or negedge nResetIn)
    if (!nResetIn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      col_q <= '0;
      fdat_q <= '0;
      res_q <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      col_q <= col_d;
      fdat_q <= fdat_d;
      res_q <= res_d;
      start_q <= start_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_fir_block_sequencer.sv
// tb_fir_block_sequencer: vector table, directed corner sequences and a randomized scoreboard run.
module tb_fir_block_sequencer;
  localparam int N = 4;
  logic clkIn = 0, nResetIn = 0, sampleValidIn = 0, resultReadyIn = 0;
  logic firBusyIn = 0, firDoneIn = 0;
  logic [15:0] sampleIn = '0;
  logic [127:0] firDataIn = '0;
  logic sampleReadyOut, resultValidOut, firStartOut, errorOut;
  logic [31:0] resultOut;
  logic [63:0] firDataOut;
  int n_tests = 0, n_fail = 0;
  always #5 clkIn = ~clkIn;
  fir_block_sequencer #(.SAMPLES_NUM(N), .TIMEOUT_CYCLES(16)) dut (
    .clkIn(clkIn), .nResetIn(nResetIn), .sampleValidIn(sampleValidIn), .sampleIn(sampleIn),
    .sampleReadyOut(sampleReadyOut), .resultValidOut(resultValidOut), .resultOut(resultOut),
    .resultReadyIn(resultReadyIn), .firStartOut(firStartOut), .firDataOut(firDataOut),
    .firBusyIn(firBusyIn), .firDoneIn(firDoneIn), .firDataIn(firDataIn), .errorOut(errorOut)
  );
  typedef struct {
    logic [0:3][15:0] s;
    logic [63:0] blk;
    logic [127:0] fd;
    logic [0:3][31:0] r;
  } vec_t;
  vec_t tv[3];
  logic [0:3][31:0] abcd;
  logic mon_en = 0;
  logic [63:0] bq[$];
  logic [31:0] rq[$];
  logic [63:0] pb = '0;
  int pn = 0, nblk = 0, fdelay = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clkIn);
    #1;
  endtask
  task automatic send(input logic [15:0] v);
    sampleValidIn = 1;
    sampleIn = v;
    for (int i = 0; i < 50 && !sampleReadyOut; i++) tick;
    check("send_ready", sampleReadyOut, 1);
    tick;
    sampleValidIn = 0;
  endtask
  task automatic send4(input logic [0:3][15:0] s);
    for (int k = 0; k < 4; k++) send(s[k]);
  endtask
  task automatic fire_done(input logic [127:0] d);
    firDataIn = d;
    firDoneIn = 1;
    tick;
    firDoneIn = 0;
  endtask
  task automatic do_reset;
    nResetIn = 0;
    sampleValidIn = 0;
    resultReadyIn = 0;
    firBusyIn = 0;
    firDoneIn = 0;
    fdelay = 0;
    tick;
    tick;
    nResetIn = 1;
    tick;
  endtask
  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, sampleReadyOut, 1);
    check({tag, "_valid"}, resultValidOut, 0);
    check({tag, "_result"}, resultOut, 0);
    check({tag, "_start"}, firStartOut, 0);
    check({tag, "_fdata"}, firDataOut, 0);
    check({tag, "_error"}, errorOut, 0);
  endtask
  task automatic filter_step;
    firDoneIn = 0;
    if (firStartOut) begin
      firBusyIn = 1;
      fdelay = $urandom_range(1, 8);
    end else if (fdelay > 0) begin
      fdelay--;
      if (fdelay == 0) begin
        firBusyIn = 0;
        firDoneIn = 1;
        firDataIn = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask
  always @(negedge clkIn)
    if (mon_en) begin
      if (firStartOut) begin
        check("rnd_start_pending", bq.size() != 0, 1);
        if (bq.size() != 0) check("rnd_blk", firDataOut, bq.pop_front());
        nblk++;
      end
      check("rnd_ready", sampleReadyOut, bq.size() == 0);
      if (sampleValidIn && sampleReadyOut) begin
        pb[16*pn +: 16] = sampleIn;
        pn++;
        if (pn == N) begin
          bq.push_back(pb);
          pn = 0;
        end
      end
      if (firDoneIn)
        for (int k = N-1; k >= 0; k--) rq.push_back(firDataIn[32*k +: 32]);
      if (resultValidOut && resultReadyIn) begin
        check("rnd_res_pending", rq.size() != 0, 1);
        if (rq.size() != 0) check("rnd_res", resultOut, rq.pop_front());
      end
      check("rnd_err", errorOut, 0);
    end
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end
  initial begin
    tv[0] = '{s: {16'd1, 16'd2, 16'd3, 16'd4}, blk: 64'h0004_0003_0002_0001,
              fd: 128'h0000000A_0000000B_0000000C_0000000D, r: {32'hA, 32'hB, 32'hC, 32'hD}};
    tv[1] = '{s: {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000}, blk: 64'h0000_FFFF_7FFF_8000,
              fd: 128'hDEADBEEF_00000001_80000000_FFFFFFFF,
              r: {32'hDEADBEEF, 32'h1, 32'h80000000, 32'hFFFFFFFF}};
    tv[2] = '{s: {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, blk: 64'hDEF0_9ABC_5678_1234,
              fd: 128'h11111111_22222222_33333333_44444444,
              r: {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}};
    abcd = {32'hA, 32'hB, 32'hC, 32'hD};
    #1;
    check_reset_values("reset");
    do_reset;
    foreach (tv[v]) begin
      send4(tv[v].s);
      check("pack_no_early_start", firStartOut, 0);
      check("pack_full", sampleReadyOut, 0);
      tick;
      check("pack_start", firStartOut, 1);
      check("pack_data", firDataOut, tv[v].blk);
      tick;
      check("pack_start_width", firStartOut, 0);
      tick;
      tick;
      fire_done(tv[v].fd);
      resultReadyIn = 1;
      for (int k = 0; k < 4; k++) begin
        check("unpack_valid", resultValidOut, 1);
        check("unpack_res", resultOut, tv[v].r[k]);
        tick;
      end
      check("unpack_end", resultValidOut, 0);
      resultReadyIn = 0;
    end
    send4({16'd10, 16'd20, 16'd30, 16'd40});
    tick;
    tick;
    fire_done(tv[0].fd);
    repeat (5) begin
      check("bp_valid", resultValidOut, 1);
      check("bp_hold", resultOut, 32'hA);
      tick;
    end
    resultReadyIn = 1;
    for (int k = 0; k < 4; k++) begin
      check("bp_res", resultOut, abcd[k]);
      tick;
    end
    check("bp_end", resultValidOut, 0);
    resultReadyIn = 0;
    send4(tv[0].s);
    tick;
    tick;
    fire_done(tv[0].fd);
    for (int i = 0; i < 6; i++) begin
      sampleValidIn = 1;
      sampleIn = i < 4 ? 16'(5 + i) : 16'd9;
      resultReadyIn = 1;
      check("ovl_ready", sampleReadyOut, i != 4);
      if (i < 4) check("ovl_res", resultOut, abcd[i]);
      if (i == 4) check("ovl_drained", resultValidOut, 0);
      if (i == 5) begin
        check("ovl_start", firStartOut, 1);
        check("ovl_data", firDataOut, 64'h0008_0007_0006_0005);
      end
      tick;
    end
    sampleValidIn = 0;
    resultReadyIn = 0;
    do_reset;
    firBusyIn = 1;
    send4(tv[2].s);
    for (int i = 0; i < 10; i++) begin
      check("busy_hold", firStartOut, 0);
      tick;
    end
    firBusyIn = 0;
    check("busy_fall", firStartOut, 0);
    tick;
    check("busy_start", firStartOut, 1);
    check("busy_data", firDataOut, tv[2].blk);
    tick;
    fire_done(tv[1].fd);
    resultReadyIn = 1;
    repeat (4) tick;
    resultReadyIn = 0;
    firDoneIn = 1;
    firDataIn = tv[2].fd;
    send4(tv[1].s);
    for (int i = 0; i < 3; i++) begin
      check("done_hold", firStartOut, 0);
      check("done_ignored", resultValidOut, 0);
      tick;
    end
    firDoneIn = 0;
    tick;
    check("done_start", firStartOut, 1);
    check("done_data", firDataOut, tv[1].blk);
    do_reset;
    send4(tv[0].s);
    tick;
    check("wd_start", firStartOut, 1);
`ifdef FIR_TIMEOUT_EN
    repeat (16) tick;
    check("wd_not_yet", errorOut, 0);
    tick;
    check("wd_error", errorOut, 1);
    send4(tv[2].s);
    tick;
    check("wd_relaunch", firStartOut, 1);
    check("wd_no_result", resultValidOut, 0);
    repeat (20) tick;
    check("wd_sticky", errorOut, 1);
`else
    repeat (40) tick;
    check("nowd_error", errorOut, 0);
    fire_done(tv[0].fd);
    check("nowd_valid", resultValidOut, 1);
    check("nowd_res", resultOut, 32'hA);
`endif
    do_reset;
    send4(tv[2].s);
    tick;
    tick;
    fire_done(tv[0].fd);
    send(16'd77);
    check("rst_pre_valid", resultValidOut, 1);
    nResetIn = 0;
    #1;
    check_reset_values("rst_mid");
    tick;
    nResetIn = 1;
    tick;
    check("rst_post_valid", resultValidOut, 0);
    check("rst_post_ready", sampleReadyOut, 1);
    do_reset;
    mon_en = 1;
    for (int c = 0; c < 3000; c++) begin
      sampleValidIn = $urandom_range(0, 3) != 0;
      sampleIn = 16'($urandom);
      resultReadyIn = $urandom_range(0, 3) != 0;
      filter_step;
      tick;
    end
    sampleValidIn = 0;
    resultReadyIn = 1;
    for (int c = 0; c < 200; c++) begin
      filter_step;
      tick;
    end
    mon_en = 0;
    check("rnd_drained", 64'(rq.size()), 0);
    check("rnd_no_pending", 64'(bq.size()), 0);
    check("rnd_blocks_seen", nblk > 10, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
